antares_pipeline_controller: RTL and testbench

Central stall/flush sequencer for the five-stage Antares pipeline. It collects stall requests from IF, ID, EX and MEM plus the exception request from MEM. It drives the per-stage stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, so a hold in a later stage freezes every earlier stage and injects a bubble downstream. A small state machine sequences exception redirects, and a saturating counter reports front-end stall cycles for performance monitoring.

---
 rtl/antares_pipeline_controller.sv | 146 ++++++++++++++
 tb/tb_antares_pipeline_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/antares_pipeline_controller.sv
// ---------------------------------------------------------------------------
// antares_pipeline_controller
//
// Central stall/flush sequencer for the five-stage Antares pipeline.
// A hold in a later stage freezes every earlier stage and puts a bubble into
// the stage downstream of the hold. A three-state machine sequences exception
// redirects, and a saturating counter reports front-end stall cycles.
//
// Parameters:
//   EXC_HOLD   - number of cycles REDIRECT lasts (1..15)
//   CNT_WIDTH  - width of the stall-cycle counter
//
// Ports:
//   clk, rst_n        - clock and asynchronous active-low reset
//   if_stall_req      - instruction memory not ready
//   id_hazard         - non-forwardable load-use / branch-operand hazard
//   ex_busy           - multi-cycle mult/div unit busy
//   mem_stall_req     - data memory transaction not complete
//   exc_req           - exception/interrupt committed in MEM (level)
//   *_stall           - hold the pipeline register feeding the next stage
//   *_flush           - replace the instruction leaving that stage by a bubble
//   exc_redirect      - PC loads the exception vector this cycle
//   exc_ack           - one-cycle pulse on the first REDIRECT cycle
//   stall_cycles      - saturating count of cycles with if_stall high
// ---------------------------------------------------------------------------
module antares_pipeline_controller #(
    parameter int EXC_HOLD  = 1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_stall_req,
    input  logic                 id_hazard,
    input  logic                 ex_busy,
    input  logic                 mem_stall_req,
    input  logic                 exc_req,
    output logic                 if_stall,
    output logic                 id_stall,
    output logic                 ex_stall,
    output logic                 mem_stall,
    output logic                 if_flush,
    output logic                 id_flush,
    output logic                 ex_flush,
    output logic                 mem_flush,
    output logic                 exc_redirect,
    output logic                 exc_ack,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [3:0]           HOLD_INIT = 4'(EXC_HOLD);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    state_t     state;
    state_t     next_state;
    logic [3:0] hold_cnt;
    logic [3:0] next_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            hold_cnt <= 4'd0;
        end else begin
            state    <= next_state;
            hold_cnt <= next_hold;
        end
    end

    // Stall chain outside REDIRECT: a stage only injects a bubble when its own
    // hold is not already masked by a later-stage hold, so nothing is lost or
    // duplicated. REDIRECT overrides everything and drains the pipe.
    always_comb begin
        next_state   = state;
        next_hold    = hold_cnt;
        mem_stall    = mem_stall_req;
        ex_stall     = mem_stall_req | ex_busy;
        id_stall     = mem_stall_req | ex_busy | id_hazard;
        if_stall     = mem_stall_req | ex_busy | id_hazard | if_stall_req;
        mem_flush    = mem_stall_req;
        ex_flush     = ex_busy & ~mem_stall_req;
        id_flush     = id_hazard & ~(mem_stall_req | ex_busy);
        if_flush     = 1'b0;
        exc_redirect = 1'b0;
        exc_ack      = 1'b0;

        case (state)
            RUN: begin
                if (exc_req) begin
                    if (mem_stall_req) begin
                        next_state = WAIT_MEM;
                    end else begin
                        next_state = REDIRECT;
                        next_hold  = HOLD_INIT;
                    end
                end
            end
            WAIT_MEM: begin
                // The in-flight memory access always completes first.
                if (!mem_stall_req) begin
                    next_state = REDIRECT;
                    next_hold  = HOLD_INIT;
                end
            end
            REDIRECT: begin
                mem_stall    = 1'b0;
                ex_stall     = 1'b0;
                id_stall     = 1'b0;
                if_stall     = 1'b0;
                mem_flush    = 1'b1;
                ex_flush     = 1'b1;
                id_flush     = 1'b1;
                if_flush     = 1'b1;
                exc_redirect = 1'b1;
                // The counter only counts down, so it equals the load value
                // exactly on the first REDIRECT cycle.
                exc_ack      = (hold_cnt == HOLD_INIT);
                if (hold_cnt <= 4'd1) begin
                    next_state = RUN;
                    next_hold  = 4'd0;
                end else begin
                    next_hold  = hold_cnt - 4'd1;
                end
            end
            default: begin
                next_state = RUN;
                next_hold  = 4'd0;
            end
        endcase
    end

    // Front-end stall counter saturates instead of wrapping and survives
    // exceptions; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (if_stall && (stall_cycles != CNT_MAX)) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_antares_pipeline_controller.sv
// ---------------------------------------------------------------------------
// tb_antares_pipeline_controller
//
// Directed-vector bench for antares_pipeline_controller. Two instances share
// the same inputs: a 32-bit counter instance and a 4-bit counter instance for
// the saturation case. Both use EXC_HOLD = 2. Outputs are packed as
// {if_stall,id_stall,ex_stall,mem_stall,if_flush,id_flush,ex_flush,mem_flush,
//  exc_redirect,exc_ack} and compared against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_antares_pipeline_controller;

    logic        clk;
    logic        rst_n;
    logic        if_stall_req;
    logic        id_hazard;
    logic        ex_busy;
    logic        mem_stall_req;
    logic        exc_req;

    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic        exc_redirect, exc_ack;
    logic [31:0] stall_cycles;

    logic        s_if_stall, s_id_stall, s_ex_stall, s_mem_stall;
    logic        s_if_flush, s_id_flush, s_ex_flush, s_mem_flush;
    logic        s_exc_redirect, s_exc_ack;
    logic [3:0]  s_stall_cycles;

    int vectors;
    int miscompares;

    antares_pipeline_controller #(.EXC_HOLD(2), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_stall_req(if_stall_req), .id_hazard(id_hazard), .ex_busy(ex_busy),
        .mem_stall_req(mem_stall_req), .exc_req(exc_req),
        .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
        .exc_redirect(exc_redirect), .exc_ack(exc_ack), .stall_cycles(stall_cycles)
    );

    antares_pipeline_controller #(.EXC_HOLD(2), .CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .if_stall_req(if_stall_req), .id_hazard(id_hazard), .ex_busy(ex_busy),
        .mem_stall_req(mem_stall_req), .exc_req(exc_req),
        .if_stall(s_if_stall), .id_stall(s_id_stall), .ex_stall(s_ex_stall), .mem_stall(s_mem_stall),
        .if_flush(s_if_flush), .id_flush(s_id_flush), .ex_flush(s_ex_flush), .mem_flush(s_mem_flush),
        .exc_redirect(s_exc_redirect), .exc_ack(s_exc_ack), .stall_cycles(s_stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] outs();
        return {if_stall, id_stall, ex_stall, mem_stall,
                if_flush, id_flush, ex_flush, mem_flush,
                exc_redirect, exc_ack};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive {if_stall_req,id_hazard,ex_busy,mem_stall_req,exc_req} and let
    // the combinational outputs settle.
    task automatic applyStimulus(input logic [4:0] v);
        {if_stall_req, id_hazard, ex_busy, mem_stall_req, exc_req} = v;
        #1;
    endtask

    // Advance one clock: through the rising edge to the following falling edge.
    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        applyStimulus(5'b00000);
        checkOutput("reset_outs", 32'(outs()), 32'h0);
        checkOutput("reset_cnt", stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'b00000);
            checkOutput("idle_outs", 32'(outs()), 32'h0);
            nextCycle();
        end
        checkOutput("idle_cnt", stall_cycles, 32'd0);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(5'b01000);
            checkOutput("id_hazard", 32'(outs()), 32'(10'b1100_0100_00));
            nextCycle();
        end
        checkOutput("hazard_cnt", stall_cycles, 32'd2);

        applyStimulus(5'b00110);
        checkOutput("ex_mem_both", 32'(outs()), 32'(10'b1111_0001_00));
        nextCycle();
        applyStimulus(5'b00100);
        checkOutput("ex_only", 32'(outs()), 32'(10'b1110_0010_00));
        nextCycle();
        applyStimulus(5'b10000);
        checkOutput("if_only", 32'(outs()), 32'(10'b1000_0000_00));
        nextCycle();
        checkOutput("chain_cnt", stall_cycles, 32'd5);

        // Exception with memory idle plus a simultaneous hazard.
        applyStimulus(5'b01001);
        checkOutput("exc_with_hazard", 32'(outs()), 32'(10'b1100_0100_00));
        nextCycle();
        applyStimulus(5'b01010);
        checkOutput("redirect_1", 32'(outs()), 32'(10'b0000_1111_11));
        nextCycle();
        applyStimulus(5'b00000);
        checkOutput("redirect_2", 32'(outs()), 32'(10'b0000_1111_10));
        nextCycle();
        applyStimulus(5'b00000);
        checkOutput("back_to_run", 32'(outs()), 32'h0);
        nextCycle();
        checkOutput("redirect_cnt", stall_cycles, 32'd6);

        // Exception while memory is busy for three more cycles.
        applyStimulus(5'b00011);
        checkOutput("exc_mem_busy", 32'(outs()), 32'(10'b1111_0001_00));
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'b00010);
            checkOutput("wait_mem", 32'(outs()), 32'(10'b1111_0001_00));
            nextCycle();
        end
        applyStimulus(5'b00000);
        checkOutput("wait_mem_done", 32'(outs()), 32'h0);
        nextCycle();
        applyStimulus(5'b00000);
        checkOutput("late_redirect_1", 32'(outs()), 32'(10'b0000_1111_11));
        nextCycle();
        applyStimulus(5'b00001);
        checkOutput("late_redirect_2", 32'(outs()), 32'(10'b0000_1111_10));
        nextCycle();
        applyStimulus(5'b00001);
        checkOutput("exc_still_high", 32'(outs()), 32'h0);
        nextCycle();
        applyStimulus(5'b00000);
        checkOutput("new_redirect", 32'(outs()), 32'(10'b0000_1111_11));
        checkOutput("wait_cnt", stall_cycles, 32'd10);
        checkOutput("small_cnt", 32'(s_stall_cycles), 32'd10);

        // Asynchronous reset in the middle of REDIRECT.
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outs", 32'(outs()), 32'h0);
        checkOutput("async_reset_cnt", stall_cycles, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(5'b00000);
        checkOutput("after_reset", 32'(outs()), 32'h0);
        nextCycle();

        // Saturation of the 4-bit counter instance.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(5'b10000);
            nextCycle();
        end
        checkOutput("small_cnt_14", 32'(s_stall_cycles), 32'd14);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(5'b10000);
            nextCycle();
        end
        checkOutput("small_cnt_sat", 32'(s_stall_cycles), 32'd15);
        checkOutput("big_cnt_20", stall_cycles, 32'd20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
